// File: rtl/lcd_pkg.sv
// Shared definitions for the 2x16 HD44780-style LCD responder.
// Holds instruction opcodes, DDRAM geometry constants and the address
// helpers used by both the responder top and its DDRAM sub-module.
package lcd_pkg;

    // Instruction opcodes; the highest set bit of an instruction selects it.
    localparam logic [7:0] SET_DDRAM  = 8'h80;
    localparam logic [7:0] SET_CGRAM  = 8'h40;
    localparam logic [7:0] FUNC_SET   = 8'h20;
    localparam logic [7:0] CUR_SHIFT  = 8'h10;
    localparam logic [7:0] DISP_CTRL  = 8'h08;
    localparam logic [7:0] ENTRY_MODE = 8'h04;
    localparam logic [7:0] RET_HOME   = 8'h02;
    localparam logic [7:0] CLR_DISP   = 8'h01;

    localparam logic [7:0]  SPACE_CHAR  = 8'h20;
    localparam logic [6:0]  LINE1_BASE  = 7'h00;
    localparam logic [6:0]  LINE2_BASE  = 7'h40;
    localparam int unsigned LINE_LEN    = 16;
    localparam int unsigned DDRAM_DEPTH = 2 * LINE_LEN;

    localparam logic [6:0] LINE1_LAST = LINE1_BASE + 7'(LINE_LEN - 1);
    localparam logic [6:0] LINE2_LAST = LINE2_BASE + 7'(LINE_LEN - 1);

    typedef enum logic [3:0] {
        OP_NOP,
        OP_CLR,
        OP_HOME,
        OP_ENTRY,
        OP_DISP,
        OP_CURSOR,
        OP_FUNC,
        OP_CGRAM,
        OP_DDRAM
    } lcd_op_e;

    function automatic lcd_op_e decode_op(input logic [7:0] d);
        if      ((d & SET_DDRAM)  != '0) return OP_DDRAM;
        else if ((d & SET_CGRAM)  != '0) return OP_CGRAM;
        else if ((d & FUNC_SET)   != '0) return OP_FUNC;
        else if ((d & CUR_SHIFT)  != '0) return OP_CURSOR;
        else if ((d & DISP_CTRL)  != '0) return OP_DISP;
        else if ((d & ENTRY_MODE) != '0) return OP_ENTRY;
        else if ((d & RET_HOME)   != '0) return OP_HOME;
        else if ((d & CLR_DISP)   != '0) return OP_CLR;
        else                             return OP_NOP;
    endfunction

    function automatic logic addr_valid(input logic [6:0] a);
        return (a[5:4] == 2'b00);
    endfunction

    function automatic logic [4:0] addr_index(input logic [6:0] a);
        return {a[6], a[3:0]};
    endfunction

    // Cursor advance: the two lines form one 32-entry ring in either direction.
    function automatic logic [6:0] next_addr(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == LINE1_LAST)      return LINE2_BASE;
            else if (a == LINE2_LAST) return LINE1_BASE;
            else                      return a + 7'd1;
        end else begin
            if (a == LINE2_BASE)      return LINE1_LAST;
            else if (a == LINE1_BASE) return LINE2_LAST;
            else                      return a - 7'd1;
        end
    endfunction

endpackage

// File: rtl/lcd_ddram_2x16.sv
// Shadow DDRAM for a 2x16 display: 32 x 8 flops, reset and clear to space.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clr_i       single-cycle clear of all entries to 0x20
//   we_i        write enable; waddr_i/wdata_i give the DDRAM address and data
//   raddr_i     DDRAM address to read; rdata_o is registered (0x20 if invalid)
module lcd_ddram_2x16
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       we_i,
    input  logic [6:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [6:0] raddr_i,
    output logic [7:0] rdata_o
);

    logic [7:0] mem_q [DDRAM_DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DDRAM_DEPTH; i++) mem_q[i] <= SPACE_CHAR;
        end else if (clr_i) begin
            for (int unsigned i = 0; i < DDRAM_DEPTH; i++) mem_q[i] <= SPACE_CHAR;
        end else if (we_i && addr_valid(waddr_i)) begin
            mem_q[addr_index(waddr_i)] <= wdata_i;
        end
    end

    // Reads the pre-edge array contents, so a same-cycle write returns old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= SPACE_CHAR;
        end else begin
            rdata_q <= addr_valid(raddr_i) ? mem_q[addr_index(raddr_i)] : SPACE_CHAR;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lcd2x16_responder.sv
// Responder model of a write-only HD44780-style 2x16 LCD.
// Decodes EN falling-edge strobes into instruction/data writes, keeps a
// shadow DDRAM, display mode flags, a busy timer and sticky error flags.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   LCD_DATA, LCD_RW, LCD_EN, LCD_RS LCD bus inputs
//   rd_index / rd_char              registered DDRAM inspection port
//   wr_strobe / wr_addr             one-cycle pulse per stored character
//   busy, disp_on, two_line         model status
//   addr_err, busy_err, rw_err      sticky error flags
module lcd2x16_responder
    import lcd_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES = 40,
    parameter int unsigned CLR_CYCLES  = 1600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] LCD_DATA,
    input  logic       LCD_RW,
    input  logic       LCD_EN,
    input  logic       LCD_RS,
    input  logic [6:0] rd_index,
    output logic [7:0] rd_char,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic       busy,
    output logic       disp_on,
    output logic       two_line,
    output logic       addr_err,
    output logic       busy_err,
    output logic       rw_err
);

    localparam int unsigned MAX_CYCLES = (CLR_CYCLES > BUSY_CYCLES) ? CLR_CYCLES : BUSY_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    logic             en_q;
    logic [6:0]       addr_q, addr_d;
    logic             inc_q, inc_d;
    logic             disp_q, disp_d;
    logic             two_q, two_d;
    logic             aerr_q, aerr_d;
    logic             berr_q, berr_d;
    logic             rwerr_q, rwerr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wstb_q, wstb_d;
    logic [6:0]       waddr_q, waddr_d;

    logic strobe;
    logic mem_clr;
    logic mem_we;

    assign strobe = en_q & ~LCD_EN;
    assign busy   = (cnt_q != '0);

    always_comb begin
        addr_d  = addr_q;
        inc_d   = inc_q;
        disp_d  = disp_q;
        two_d   = two_q;
        aerr_d  = aerr_q;
        berr_d  = berr_q;
        rwerr_d = rwerr_q;
        cnt_d   = busy ? cnt_q - CNT_W'(1) : '0;
        wstb_d  = 1'b0;
        waddr_d = waddr_q;
        mem_clr = 1'b0;
        mem_we  = 1'b0;

        if (strobe) begin
            if (LCD_RW) begin
                rwerr_d = 1'b1;
            end else if (busy) begin
                berr_d = 1'b1;
            end else begin
                cnt_d = CNT_W'(BUSY_CYCLES);
                if (LCD_RS) begin
                    if (addr_valid(addr_q)) begin
                        mem_we  = 1'b1;
                        wstb_d  = 1'b1;
                        waddr_d = addr_q;
                        addr_d  = next_addr(addr_q, inc_q);
                    end else begin
                        aerr_d = 1'b1;
                    end
                end else begin
                    case (decode_op(LCD_DATA))
                        OP_DDRAM: begin
                            addr_d = LCD_DATA[6:0];
                            if (!addr_valid(LCD_DATA[6:0])) aerr_d = 1'b1;
                        end
                        OP_FUNC:  two_d  = LCD_DATA[3];
                        OP_DISP:  disp_d = LCD_DATA[2];
                        OP_ENTRY: inc_d  = LCD_DATA[1];
                        OP_HOME:  addr_d = LINE1_BASE;
                        OP_CLR: begin
                            mem_clr = 1'b1;
                            addr_d  = LINE1_BASE;
                            inc_d   = 1'b1;
                            cnt_d   = CNT_W'(CLR_CYCLES);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q    <= 1'b0;
            addr_q  <= LINE1_BASE;
            inc_q   <= 1'b1;
            disp_q  <= 1'b0;
            two_q   <= 1'b0;
            aerr_q  <= 1'b0;
            berr_q  <= 1'b0;
            rwerr_q <= 1'b0;
            cnt_q   <= '0;
            wstb_q  <= 1'b0;
            waddr_q <= '0;
        end else begin
            en_q    <= LCD_EN;
            addr_q  <= addr_d;
            inc_q   <= inc_d;
            disp_q  <= disp_d;
            two_q   <= two_d;
            aerr_q  <= aerr_d;
            berr_q  <= berr_d;
            rwerr_q <= rwerr_d;
            cnt_q   <= cnt_d;
            wstb_q  <= wstb_d;
            waddr_q <= waddr_d;
        end
    end

    lcd_ddram_2x16 u_ddram (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (mem_clr),
        .we_i    (mem_we),
        .waddr_i (addr_q),
        .wdata_i (LCD_DATA),
        .raddr_i (rd_index),
        .rdata_o (rd_char)
    );

    assign wr_strobe = wstb_q;
    assign wr_addr   = waddr_q;
    assign disp_on   = disp_q;
    assign two_line  = two_q;
    assign addr_err  = aerr_q;
    assign busy_err  = berr_q;
    assign rw_err    = rwerr_q;

endmodule

// File: tb/tb_lcd2x16_responder.sv
// Self-checking bench for lcd2x16_responder with a behavioural LCD model.
module tb_lcd2x16_responder;

    localparam int unsigned BUSY = 12;
    localparam int unsigned CLR  = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] LCD_DATA;
    logic       LCD_RW;
    logic       LCD_EN;
    logic       LCD_RS;
    logic [6:0] rd_index;
    logic [7:0] rd_char;
    logic       wr_strobe;
    logic [6:0] wr_addr;
    logic       busy;
    logic       disp_on;
    logic       two_line;
    logic       addr_err;
    logic       busy_err;
    logic       rw_err;

    lcd2x16_responder #(
        .BUSY_CYCLES (BUSY),
        .CLR_CYCLES  (CLR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .LCD_DATA  (LCD_DATA),
        .LCD_RW    (LCD_RW),
        .LCD_EN    (LCD_EN),
        .LCD_RS    (LCD_RS),
        .rd_index  (rd_index),
        .rd_char   (rd_char),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .busy      (busy),
        .disp_on   (disp_on),
        .two_line  (two_line),
        .addr_err  (addr_err),
        .busy_err  (busy_err),
        .rw_err    (rw_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Behavioural model: memory indexed by full 7-bit DDRAM address.
    logic [7:0] m_mem [0:127];
    int         m_addr;
    bit         m_inc, m_disp, m_two, m_aerr, m_berr, m_rwerr;
    int         m_bs, m_bl;
    logic [6:0] m_wa;

    function automatic bit m_valid(int a);
        return (a >= 0 && a <= 15) || (a >= 64 && a <= 79);
    endfunction

    function automatic int m_next(int a, bit inc);
        int line = (a >= 64) ? 1 : 0;
        int pos  = a % 16;
        if (inc) return (pos == 15) ? (line ? 0 : 64) : a + 1;
        else     return (pos == 0) ? (line ? 15 : 79) : a - 1;
    endfunction

    function automatic bit m_busy_at(int c);
        return (c >= m_bs) && (c < m_bs + m_bl);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;
        m_addr = 0; m_inc = 1; m_disp = 0; m_two = 0;
        m_aerr = 0; m_berr = 0; m_rwerr = 0;
        m_bs = 0; m_bl = 0; m_wa = '0;
    endtask

    task automatic model_strobe(input bit rs, input bit rw, input logic [7:0] d,
                                input int s, output bit ew);
        ew = 0;
        if (rw) begin m_rwerr = 1; return; end
        if (m_busy_at(s - 1)) begin m_berr = 1; return; end
        m_bs = s; m_bl = BUSY;
        if (rs) begin
            if (m_valid(m_addr)) begin
                m_mem[m_addr] = d; m_wa = 7'(m_addr); ew = 1;
                m_addr = m_next(m_addr, m_inc);
            end else m_aerr = 1;
        end else if (d[7]) begin
            m_addr = int'(d) - 128;
            if (!m_valid(m_addr)) m_aerr = 1;
        end else if (d[6]) begin
        end else if (d[5]) m_two = d[3];
        else if (d[4]) begin
        end else if (d[3]) m_disp = d[2];
        else if (d[2]) m_inc = d[1];
        else if (d[1]) m_addr = 0;
        else if (d[0]) begin
            for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;
            m_addr = 0; m_inc = 1; m_bl = CLR;
        end
    endtask

    // One bus transaction: EN high for 'hold' cycles, strobe on the falling edge,
    // then outputs are compared with the model one sample after the strobe edge.
    task automatic lcd_xfer(input bit rs, input bit rw, input logic [7:0] d,
                            input int hold, input string tag);
        bit ew;
        int s;
        LCD_RS = rs; LCD_RW = rw; LCD_DATA = d; LCD_EN = 1'b1;
        repeat (hold) @(posedge clk);
        #1 LCD_EN = 1'b0;
        @(posedge clk); #1;
        s = cyc;
        model_strobe(rs, rw, d, s, ew);
        LCD_DATA = 8'($urandom); LCD_RS = 1'($urandom); LCD_RW = 1'($urandom);
        checks += 8;
        if (wr_strobe !== ew) begin errors++; $display("FAIL %s wr_strobe: got %b want %b", tag, wr_strobe, ew); end
        if (wr_addr !== m_wa) begin errors++; $display("FAIL %s wr_addr: got %h want %h", tag, wr_addr, m_wa); end
        if (busy !== m_busy_at(cyc)) begin errors++; $display("FAIL %s busy: got %b want %b", tag, busy, m_busy_at(cyc)); end
        if (disp_on !== m_disp) begin errors++; $display("FAIL %s disp_on: got %b want %b", tag, disp_on, m_disp); end
        if (two_line !== m_two) begin errors++; $display("FAIL %s two_line: got %b want %b", tag, two_line, m_two); end
        if (addr_err !== m_aerr) begin errors++; $display("FAIL %s addr_err: got %b want %b", tag, addr_err, m_aerr); end
        if (busy_err !== m_berr) begin errors++; $display("FAIL %s busy_err: got %b want %b", tag, busy_err, m_berr); end
        if (rw_err !== m_rwerr) begin errors++; $display("FAIL %s rw_err: got %b want %b", tag, rw_err, m_rwerr); end
    endtask

    task automatic read_check(input int idx, input string tag);
        logic [7:0] exp;
        rd_index = 7'(idx);
        @(posedge clk); #1;
        exp = m_valid(idx) ? m_mem[idx] : 8'h20;
        checks++;
        if (rd_char !== exp) begin
            errors++;
            $display("FAIL %s rd_char[%h]: got %h want %h", tag, idx, rd_char, exp);
        end
    endtask

    task automatic check_all_mem(input string tag);
        for (int i = 0; i < 16; i++) read_check(i, tag);
        for (int i = 64; i < 80; i++) read_check(i, tag);
    endtask

    task automatic wait_idle();
        while (cyc < m_bs + m_bl) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; LCD_EN = 1'b0; LCD_RS = 1'b0; LCD_RW = 1'b0;
        LCD_DATA = 8'h00; rd_index = 7'h00;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        checks += 4;
        if (busy !== 1'b0 || disp_on !== 1'b0 || two_line !== 1'b0) begin
            errors++; $display("FAIL reset status: got busy=%b disp=%b two=%b want 0 0 0", busy, disp_on, two_line);
        end
        if ({addr_err, busy_err, rw_err} !== 3'b000) begin
            errors++; $display("FAIL reset errs: got %b want 000", {addr_err, busy_err, rw_err});
        end
        if (wr_strobe !== 1'b0 || wr_addr !== 7'h00) begin
            errors++; $display("FAIL reset wr: got %b/%h want 0/00", wr_strobe, wr_addr);
        end
        if (rd_char !== 8'h20) begin
            errors++; $display("FAIL reset rd_char: got %h want 20", rd_char);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        read_check(8'h05, "reset_rd05");
        read_check(8'h4A, "reset_rd4A");
    endtask

    task automatic test_writer_init();
        logic [7:0] seq [5] = '{8'h38, 8'h0C, 8'h01, 8'h06, 8'h80};
        foreach (seq[i]) begin
            wait_idle(); repeat (2) @(posedge clk); #1;
            lcd_xfer(1'b0, 1'b0, seq[i], 1 + i, "init_instr");
        end
        wait_idle(); lcd_xfer(1'b1, 1'b0, 8'h4E, 2, "init_N");
        wait_idle(); lcd_xfer(1'b1, 1'b0, 8'h6F, 1, "init_o");
        read_check(8'h00, "init_rd00");
        read_check(8'h01, "init_rd01");
    endtask

    task automatic test_wrap();
        wait_idle(); lcd_xfer(1'b0, 1'b0, 8'hCF, 1, "wrap_addr");
        wait_idle(); lcd_xfer(1'b1, 1'b0, 8'h41, 1, "wrap_A");
        wait_idle(); lcd_xfer(1'b1, 1'b0, 8'h42, 1, "wrap_B");
        read_check(8'h4F, "wrap_rd4F");
        read_check(8'h00, "wrap_rd00");
    endtask

    task automatic test_decrement();
        wait_idle(); lcd_xfer(1'b0, 1'b0, 8'h04, 1, "dec_mode");
        wait_idle(); lcd_xfer(1'b0, 1'b0, 8'hC0, 1, "dec_addr");
        wait_idle(); lcd_xfer(1'b1, 1'b0, 8'h58, 1, "dec_X");
        wait_idle(); lcd_xfer(1'b1, 1'b0, 8'h59, 1, "dec_Y");
        read_check(8'h40, "dec_rd40");
        read_check(8'h0F, "dec_rd0F");
        wait_idle(); lcd_xfer(1'b0, 1'b0, 8'h06, 1, "dec_restore");
    endtask

    task automatic test_busy_timing();
        wait_idle(); lcd_xfer(1'b1, 1'b0, 8'h7A, 3, "bt_write");
        for (int i = 0; i < int'(BUSY) + 3; i++) begin
            @(posedge clk); #1;
            checks += 2;
            if (busy !== m_busy_at(cyc)) begin
                errors++; $display("FAIL busy_timing[%0d]: got %b want %b", i, busy, m_busy_at(cyc));
            end
            if (wr_strobe !== 1'b0) begin
                errors++; $display("FAIL busy_timing wr_strobe[%0d]: got %b want 0", i, wr_strobe);
            end
        end
    endtask

    task automatic test_clear_busy();
        wait_idle(); lcd_xfer(1'b0, 1'b0, 8'h01, 1, "clr_instr");
        repeat (3) @(posedge clk); #1;
        lcd_xfer(1'b1, 1'b0, 8'h31, 1, "clr_busy_write");
        check_all_mem("clr_mem");
        wait_idle(); lcd_xfer(1'b1, 1'b0, 8'h31, 1, "clr_after_write");
        read_check(8'h00, "clr_rd00");
    endtask

    task automatic test_errors();
        wait_idle(); lcd_xfer(1'b0, 1'b0, 8'hA0, 1, "err_addr");
        wait_idle(); lcd_xfer(1'b1, 1'b0, 8'h55, 1, "err_data");
        wait_idle(); lcd_xfer(1'b0, 1'b1, 8'h80, 2, "err_rw");
        check_all_mem("err_mem");
    endtask

    task automatic test_reset_mid_op();
        wait_idle(); lcd_xfer(1'b0, 1'b0, 8'h80, 1, "rmo_home");
        wait_idle(); lcd_xfer(1'b1, 1'b0, 8'h99, 1, "rmo_write");
        lcd_xfer(1'b0, 1'b0, 8'h01, 1, "rmo_clr_busy");
        wait_idle(); lcd_xfer(1'b0, 1'b0, 8'h01, 1, "rmo_clr");
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        checks += 2;
        if (busy !== 1'b0 || {addr_err, busy_err, rw_err} !== 3'b000) begin
            errors++; $display("FAIL reset_mid busy/errs: got %b/%b want 0/000", busy, {addr_err, busy_err, rw_err});
        end
        if (rd_char !== 8'h20) begin
            errors++; $display("FAIL reset_mid rd_char: got %h want 20", rd_char);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid busy after: got %b want 0", busy);
        end
        check_all_mem("rmo_mem");
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            int k = int'($urandom_range(0, 99));
            logic [7:0] r = 8'($urandom);
            bit rs = 0, rw = 0;
            logic [7:0] d;
            if (k < 45)      begin rs = 1; d = r; end
            else if (k < 55) d = ($urandom_range(0, 4) != 0) ?
                                 (8'h80 | (r & 8'h40) | (r & 8'h0F)) : (8'h80 | r);
            else if (k < 62) d = 8'h04 | (r & 8'h03);
            else if (k < 67) d = 8'h20 | (r & 8'h1F);
            else if (k < 72) d = 8'h08 | (r & 8'h07);
            else if (k < 75) d = 8'h02 | (r & 8'h01);
            else if (k < 77) d = 8'h01;
            else if (k < 80) d = 8'h40 | (r & 8'h3F);
            else if (k < 83) d = 8'h10 | (r & 8'h0F);
            else if (k < 85) d = 8'h00;
            else if (k < 90) begin rw = 1; rs = 1'($urandom); d = r; end
            else             begin rs = 1; d = r; end
            if ($urandom_range(0, 99) < 85) wait_idle();
            lcd_xfer(rs, rw, d, int'($urandom_range(1, 4)), "random");
            if ($urandom_range(0, 9) == 0) read_check(int'($urandom_range(0, 127)), "random_rd");
        end
        wait_idle();
        check_all_mem("random_mem");
        read_check(8'h10, "inv_rd10");
        read_check(8'h3F, "inv_rd3F");
        read_check(8'h7F, "inv_rd7F");
    endtask

    initial begin
        test_reset();
        test_writer_init();
        test_wrap();
        test_decrement();
        test_busy_timing();
        test_clear_busy();
        test_errors();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
